// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: operation codes, FSM states
// and the small decode helpers used by the controller and the lane logic.
package lsu_pkg;

  localparam logic [2:0] LSU_LB  = 3'd0;
  localparam logic [2:0] LSU_LBU = 3'd1;
  localparam logic [2:0] LSU_LH  = 3'd2;
  localparam logic [2:0] LSU_LHU = 3'd3;
  localparam logic [2:0] LSU_LW  = 3'd4;
  localparam logic [2:0] LSU_SB  = 3'd5;
  localparam logic [2:0] LSU_SH  = 3'd6;
  localparam logic [2:0] LSU_SW  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP,
    ERR
  } lsuState_e;

  function automatic logic is_store(input logic [2:0] op);
    return op[2] & (op != LSU_LW);
  endfunction

  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] addrLow);
    logic bad;
    bad = 1'b0;
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: bad = addrLow[0];
      LSU_LW, LSU_SW:          bad = |addrLow;
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: extends a sub-word load out of a memory word
// and merges a byte/half store into a previously read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byteOff,
  input  logic [2:0]  op,
  input  logic [15:0] wData,
  output logic [31:0] loadVal,
  output logic [31:0] mergeWord
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic [4:0]  byteBit;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    byteBit = {byteOff, 3'b000};
    selByte = word[byteBit +: 8];
    selHalf = byteOff[1] ? word[31:16] : word[15:0];

    loadVal = word;
    case (op)
      LSU_LB:  loadVal = {{24{selByte[7]}}, selByte};
      LSU_LBU: loadVal = {24'h0, selByte};
      LSU_LH:  loadVal = {{16{selHalf[15]}}, selHalf};
      LSU_LHU: loadVal = {16'h0, selHalf};
      default: loadVal = word;
    endcase

    mergeWord = word;
    if (op == LSU_SB) begin
      mergeWord[byteBit +: 8] = wData[7:0];
    end else if (op == LSU_SH) begin
      if (byteOff[1]) mergeWord[31:16] = wData;
      else            mergeWord[15:0]  = wData;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller for a word-wide data memory with
// combinational read; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req,
  input  logic [2:0]        Op,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Ready,
  output logic              Done,
  output logic              AddrErr,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemW,
  output logic              MemR,
  input  logic [DATA_W-1:0] MemRData
);

  lsuState_e         state, nextState;
  logic [2:0]        opR;
  logic [ADDR_W+1:0] addrR;
  logic [DATA_W-1:0] wDataR;
  logic [DATA_W-1:0] mergeR;
  logic [DATA_W-1:0] rDataR;
  logic [DATA_W-1:0] laneWord;
  logic [DATA_W-1:0] loadVal;
  logic [DATA_W-1:0] mergeWord;
  logic              isSubStore;

  // Bits above the memory size are deliberately dropped so addresses wrap.
  logic unusedAddrBits;
  assign unusedAddrBits = ^Addr[31:ADDR_W+2];

  assign isSubStore = (opR == LSU_SB) || (opR == LSU_SH);
  assign laneWord   = (state == WRITE) ? mergeR : MemRData;

  lsu_lane u_lane (
    .word      (laneWord),
    .byteOff   (addrR[1:0]),
    .op        (opR),
    .wData     (wDataR[15:0]),
    .loadVal   (loadVal),
    .mergeWord (mergeWord)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Req) nextState = isMisaligned(Op, Addr[1:0]) ? ERR : ACCESS;
      ACCESS:  nextState = isSubStore ? WRITE : RESP;
      WRITE:   nextState = RESP;
      RESP:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: the data registers are few and all feed visible outputs, so they
  // are reset along with the FSM to give defined values after RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      opR    <= LSU_LB;
      addrR  <= '0;
      wDataR <= '0;
      mergeR <= '0;
      rDataR <= '0;
    end else begin
      if (state == IDLE && Req) begin
        opR    <= Op;
        addrR  <= Addr[ADDR_W+1:0];
        wDataR <= WData;
      end
      if (state == ACCESS) begin
        mergeR <= MemRData;
        if (!is_store(opR)) rDataR <= loadVal;
      end
    end
  end

  always_comb begin
    Ready    = (state == IDLE);
    Done     = (state == RESP) || (state == ERR);
    AddrErr  = (state == ERR);
    RData    = rDataR;
    MemR     = 1'b0;
    MemW     = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    case (state)
      ACCESS: begin
        MemAddr = addrR[ADDR_W+1:2];
        if (opR == LSU_SW) begin
          MemW     = 1'b1;
          MemWData = wDataR;
        end else begin
          MemR = 1'b1;
        end
      end
      WRITE: begin
        MemAddr  = addrR[ADDR_W+1:2];
        MemW     = 1'b1;
        MemWData = mergeWord;
      end
      default: ;
    endcase
    // A reset edge must never commit a write.
    MemW = MemW & ~RST;
  end

endmodule
